vmem_arbiter: RTL

Shares the single-port framebuffer RAM between the VGA scan-out path and a pixel-write requester (CPU/DMA). Scan reads own the port whenever the VGA controller reports active video. Pixel writes are queued in a small FIFO and drained only during blanking. The block sits between `vga`, the pixel producer, and a synchronous-read framebuffer addressed as `{v_addr[8:0], h_addr[9:0]}`.

---
 rtl/vmem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: shares a single-port framebuffer RAM between VGA scan-out
// reads and queued pixel writes. Scan reads own the port during active
// video. Pixel writes wait in a small FIFO and drain one per blanking cycle.
module vmem_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vga_valid,
    input  logic [9:0]                 vga_h_addr,
    input  logic [8:0]                 vga_v_addr,
    output logic [DATA_W-1:0]          vga_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [9:0]                 wr_h_addr,
    input  logic [8:0]                 wr_v_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [18:0]                mem_addr,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [1:0]                 state
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = 19;
    localparam int ENT_W  = ADDR_W + DATA_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Entry layout: {v_addr, h_addr, data}, so the top 19 bits are the RAM address.
    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic              rd_pend_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    // Not ready while reset is held, so nothing is accepted into a FIFO being cleared.
    assign wr_ready   = !fifo_full && !rst;
    assign push       = wr_valid && wr_ready;
    assign pop        = mem_we;
    // Head is read combinationally so a push at edge t can be written in cycle t+1.
    assign head       = fifo_mem[rd_ptr_reg];

    // Port arbitration: active video always wins, writes only during blanking.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!fifo_empty) begin
            mem_wdata = head[DATA_W-1:0];
        end
        if (vga_valid) begin
            mem_addr = {vga_v_addr, vga_h_addr};
        end else if (!fifo_empty) begin
            mem_addr = head[ENT_W-1:DATA_W];
            mem_we   = 1'b1;
        end
    end

    // Occupancy and informational state for the coming cycle.
    always_comb begin
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        if (vga_valid) begin
            state_next = ST_SCAN;
        end else if (count_next != '0) begin
            state_next = ST_DRAIN;
        end else begin
            state_next = ST_IDLE;
        end
    end

    // FIFO storage; contents need no reset because the count qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {wr_v_addr, wr_h_addr, wr_data};
        end
    end

    // Pointers, count, state and read-pending flag; reset discards the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            state_reg   <= ST_IDLE;
            rd_pend_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg   <= count_next;
            state_reg   <= state_next;
            rd_pend_reg <= vga_valid;
        end
    end

    // RAM read data belongs to the scan address issued one cycle earlier.
    assign vga_data   = rd_pend_reg ? mem_rdata : '0;
    assign fifo_count = count_reg;
    assign state      = state_reg;

endmodule
